instr_enc: RTL and testbench

INSTR_ENC -- requirements
Module: instr_enc

---
 rtl/instr_enc.sv | 125 ++++++++++++
 tb/tb_instr_enc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc.sv
// RISC-V instruction-word encoder (I/S/B/U/J) feeding a small output FIFO.
// Optional immediate range checking is compiled in with INSTR_ENC_RANGE_CHECK_EN.
module instr_enc #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  type_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] TYPE_J = 3'd1;
  localparam logic [2:0] TYPE_U = 3'd2;
  localparam logic [2:0] TYPE_S = 3'd3;
  localparam logic [2:0] TYPE_B = 3'd4;
  localparam logic [2:0] TYPE_I = 3'd5;

  logic [31:0]      enc_instr;
  logic             enc_err;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;
  logic [31:0]      instr_mem [FIFO_DEPTH];

  always_comb begin
    enc_instr = 32'h0000_0000;
    unique case (type_i)
      TYPE_I: enc_instr = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      TYPE_S: enc_instr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      TYPE_B: enc_instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
      TYPE_U: enc_instr = {imm_i[31:12], rd_i, opcode_i};
      TYPE_J: enc_instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: enc_instr = 32'h0000_0000;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic err_mem [FIFO_DEPTH];

  // A field is exactly representable when all bits above it match the sign bit.
  always_comb begin
    enc_err = 1'b1;
    unique case (type_i)
      TYPE_I, TYPE_S: enc_err = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      TYPE_B:         enc_err = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
      TYPE_J:         enc_err = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
      TYPE_U:         enc_err = |imm_i[11:0];
      default:        enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      err_mem[wr_ptr_q] <= enc_err;
    end
  end

  assign err_o = empty ? 1'b0 : err_mem[rd_ptr_q];
`else
  assign enc_err = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  // Ready is withheld during reset; when full, a same-cycle pop frees the slot.
  assign in_ready_o  = !rst_i && (!full || out_ready_i);
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign instr_o     = empty ? 32'h0000_0000 : instr_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, push and pop hit the same slot; the head is read before the edge.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= enc_instr;
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc: directed corner cases plus randomized traffic
// with random output backpressure, checked against an arithmetic reference model.
module tb_instr_enc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  type_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [31:0] imm_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];
  logic        hold_v = 1'b0;
  logic [32:0] hold_val;
  bit          rand_done;

  instr_enc #(.FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .type_i(type_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .instr_o(instr_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: returns {err, instr} computed from field positions with shifts/masks.
  function automatic logic [32:0] model(input logic [2:0] t, input logic [6:0] op,
      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w, o, f, d, r1, r2;
    logic        e;
    int          s;
    s = $signed(imm);
    o = 32'(op); f = 32'(f3) << 12; d = 32'(rd) << 7; r1 = 32'(rs1) << 15; r2 = 32'(rs2) << 20;
    w = 0; e = 1'b1;
    case (t)
      3'd5: begin
        w = ((imm & 32'hFFF) << 20) | r1 | f | d | o;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((imm & 32'h1F) << 7) | o;
        e = (s < -2048) || (s > 2047);
      end
      3'd4: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f |
            (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
        e = (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
      end
      3'd2: begin
        w = (imm & 32'hFFFF_F000) | d | o;
        e = (imm % 4096) != 0;
      end
      3'd1: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
        e = (s < -(1 << 20)) || (s >= (1 << 20)) || (imm[0] == 1'b1);
      end
      default: begin
        w = 0; e = 1'b1;
      end
    endcase
`ifndef INSTR_ENC_RANGE_CHECK_EN
    e = 1'b0;
`endif
    return {e, w};
  endfunction

  // Monitor: records accepted requests and checks every presented/popped word.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid_o) chk("head_stable", {err_o, instr_o}, hold_val);
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {err_o, instr_o}, 33'h1_FFFF_FFFF ^ {err_o, instr_o});
        end else begin
          chk("scoreboard", {err_o, instr_o}, sb_q.pop_front());
        end
      end
      if (in_valid_i && in_ready_o)
        sb_q.push_back(model(type_i, opcode_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i));
      hold_v   = out_valid_o && !out_ready_i;
      hold_val = {err_o, instr_o};
    end
  end

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    type_i = t; opcode_i = op; funct3_i = f3; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    in_valid_i = 1'b1;
  endtask

  // Holds the request until accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit ok;
    ok = 1'b0;
    set_req(t, op, f3, rd, rs1, rs2, imm);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_i);
      ok = in_ready_o;
    end
    if (!ok) chk("accept_timeout", 33'd0, 33'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_out_valid", 33'(out_valid_o), 33'd0);
    chk("reset_in_ready", 33'(in_ready_o), 33'd0);
    chk("reset_outputs", {err_o, instr_o}, 33'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_reset", 33'(in_ready_o), 33'd1);
    @(posedge clk_i); #1;

    // Known-answer words and one-cycle latency from an empty FIFO.
    out_ready_i = 1'b1;
    send(3'd5, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk_i);
    chk("latency_valid", 33'(out_valid_o), 33'd1);
    chk("kat_addi", 33'(instr_o), 33'h0_FFF0_0093);
    @(posedge clk_i); #1;
    send(3'd4, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    @(negedge clk_i);
    chk("kat_branch", 33'(instr_o), 33'h0_FE00_0EE3);
    @(posedge clk_i); #1;
    send(3'd2, 7'b0110111, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    @(negedge clk_i);
    chk("kat_lui", 33'(instr_o), 33'h0_1234_52B7);
    @(posedge clk_i); #1;
    send(3'd5, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    @(negedge clk_i);
    chk("imm_800_field", 33'(instr_o[31:20]), 33'h800);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("imm_800_err", 33'(err_o), 33'd1);
`else
    chk("imm_800_err", 33'(err_o), 33'd0);
`endif
    @(posedge clk_i); #1;
    send(3'd7, 7'h7F, 3'd7, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF);
    @(negedge clk_i);
    chk("invalid_type", 33'(instr_o), 33'd0);
    @(posedge clk_i); #1;

    // Backpressure: two fill the FIFO, third waits, then is taken with the first pop.
    out_ready_i = 1'b0;
    set_req(3'd5, 7'h13, 3'd1, 5'd1, 5'd2, 5'd0, 32'd1);
    @(negedge clk_i); chk("bp_ready_1", 33'(in_ready_o), 33'd1);
    @(posedge clk_i); #1;
    set_req(3'd5, 7'h13, 3'd2, 5'd3, 5'd4, 5'd0, 32'd2);
    @(negedge clk_i); chk("bp_ready_2", 33'(in_ready_o), 33'd1);
    @(posedge clk_i); #1;
    set_req(3'd5, 7'h13, 3'd3, 5'd5, 5'd6, 5'd0, 32'd3);
    @(negedge clk_i); chk("bp_ready_full", 33'(in_ready_o), 33'd0);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    @(negedge clk_i); chk("bp_ready_pushpop", 33'(in_ready_o), 33'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk_i); #1;
    chk("bp_drained", 33'(sb_q.size()), 33'd0);

    // Reset with two entries queued: nothing stale may emerge afterwards.
    out_ready_i = 1'b0;
    send(3'd3, 7'h23, 3'd2, 5'd0, 5'd7, 5'd8, 32'd16);
    send(3'd3, 7'h23, 3'd2, 5'd0, 5'd9, 5'd10, 32'd32);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_flush_valid", 33'(out_valid_o), 33'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_flush_ready", 33'(in_ready_o), 33'd1);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    send(3'd1, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    repeat (3) @(posedge clk_i); #1;
    chk("rst_no_stale", 33'(sb_q.size()), 33'd0);

    // Randomized traffic with random consumer stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
          send(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), rand_imm());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk_i); #1;
          out_ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join

    out_ready_i = 1'b1;
    for (int i = 0; i < 50 && (sb_q.size() != 0 || out_valid_o); i++) begin
      @(posedge clk_i); #1;
    end
    chk("final_drain", {1'b0, 31'(sb_q.size()), out_valid_o}, 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
